// File: rtl/request_arbiter_4.sv
// Four-requester round-robin arbiter with grant hold and registered outputs.
// Optional hold-timeout fairness is enabled by defining ARB_TIMEOUT_EN.
module request_arbiter_4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       gs,
  output logic       idle
);

  typedef enum logic {S_IDLE, S_OWNED} state_t;

  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_hold
    $error("MAX_HOLD must be in 2..256");
  end

  state_t     r_state;
  state_t     w_state_n;
  logic [1:0] r_last;
  logic [1:0] w_last_n;
  logic [3:0] r_grant;
  logic [1:0] r_grant_id;
  logic       r_gs;
  logic       r_idle;
  logic       w_idle_n;
  logic [3:0] w_grant_n;
  logic [1:0] w_grant_id_n;
  logic       w_gs_n;

  logic [3:0] w_req_m;
  logic [7:0] w_dbl;
  logic [1:0] w_start;
  logic [3:0] w_rot;
  logic [1:0] w_off;
  logic       w_found;
  logic [1:0] w_win;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_n;
`endif

  // Rotating priority search starting after the last owner; owner masked out
  always_comb begin
    w_req_m = req & ~r_grant;
    w_dbl   = {w_req_m, w_req_m};
    w_start = r_last + 2'd1;
    w_rot   = w_dbl[w_start +: 4];
    w_found = 1'b1;
    w_off   = 2'd0;
    priority case (1'b1)
      w_rot[0]: w_off = 2'd0;
      w_rot[1]: w_off = 2'd1;
      w_rot[2]: w_off = 2'd2;
      w_rot[3]: w_off = 2'd3;
      default:  w_found = 1'b0;
    endcase
    w_win = w_start + w_off;
  end

  // Next-state, pointer and output decode
  always_comb begin
    w_state_n = r_state;
    w_last_n  = r_last;
    w_idle_n  = en && (r_state == S_IDLE) && (req == 4'b0000);
`ifdef ARB_TIMEOUT_EN
    w_cnt_n   = r_cnt;
`endif
    if (!en) begin
      w_state_n = S_IDLE;
`ifdef ARB_TIMEOUT_EN
      w_cnt_n   = '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            w_state_n = S_OWNED;
            w_last_n  = w_win;
`ifdef ARB_TIMEOUT_EN
            w_cnt_n   = '0;
`endif
          end
        end
        S_OWNED: begin
          if (req[r_last]) begin
`ifdef ARB_TIMEOUT_EN
            if (r_cnt == HOLD_LAST) begin
              w_cnt_n = '0;
              if (w_found) w_last_n = w_win;
            end else begin
              w_cnt_n = r_cnt + 1'b1;
            end
`endif
          end else if (w_found) begin
            w_last_n = w_win;
`ifdef ARB_TIMEOUT_EN
            w_cnt_n  = '0;
`endif
          end else begin
            w_state_n = S_IDLE;
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end
    w_gs_n       = (w_state_n == S_OWNED);
    w_grant_n    = w_gs_n ? (4'b0001 << w_last_n) : 4'b0000;
    w_grant_id_n = w_gs_n ? w_last_n : 2'd0;
  end

  // State, pointer and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_last     <= 2'd3;
      r_grant    <= 4'b0000;
      r_grant_id <= 2'd0;
      r_gs       <= 1'b0;
      r_idle     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_cnt      <= '0;
`endif
    end else begin
      r_state    <= w_state_n;
      r_last     <= w_last_n;
      r_grant    <= w_grant_n;
      r_grant_id <= w_grant_id_n;
      r_gs       <= w_gs_n;
      r_idle     <= w_idle_n;
`ifdef ARB_TIMEOUT_EN
      r_cnt      <= w_cnt_n;
`endif
    end
  end

  assign grant    = r_grant;
  assign grant_id = r_grant_id;
  assign gs       = r_gs;
  assign idle     = r_idle;

endmodule

// File: tb/tb_request_arbiter_4.sv
// Self-checking bench for request_arbiter_4 with a behavioural model.
// Checks every cycle plus literal scenario expectations.
module tb_request_arbiter_4;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       gs;
  logic       idle;

  int n_cmp = 0;
  int n_bad = 0;
  int n_cyc = 0;

  int m_owner = -1;
  int m_last  = 3;
  int m_cnt   = 0;
  bit m_idle  = 1'b0;

`ifdef ARB_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  request_arbiter_4 #(.MAX_HOLD(MH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .req(req),
    .grant(grant),
    .grant_id(grant_id),
    .gs(gs),
    .idle(idle)
  );

  always #5 clk = ~clk;

  function automatic int pick(int start, int excl);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (start + k) % 4;
      if (req[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_step();
    int w;
    bit ni;
    if (!rst_n) begin
      m_owner = -1; m_last = 3; m_cnt = 0; m_idle = 1'b0;
    end else if (!en) begin
      m_owner = -1; m_cnt = 0; m_idle = 1'b0;
    end else begin
      ni = (m_owner < 0) && (req == 4'b0000);
      if (m_owner < 0) begin
        w = pick(m_last + 1, -1);
        if (w >= 0) begin
          m_owner = w; m_last = w; m_cnt = 0;
        end
      end else if (req[m_owner]) begin
        if (TO && m_cnt == MH - 1) begin
          w = pick(m_owner + 1, m_owner);
          if (w >= 0) begin
            m_owner = w; m_last = w;
          end
          m_cnt = 0;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end else begin
        w = pick(m_owner + 1, -1);
        if (w >= 0) begin
          m_owner = w; m_last = w; m_cnt = 0;
        end else begin
          m_owner = -1;
        end
      end
      m_idle = ni;
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic [3:0] q);
    logic [3:0] eg;
    logic [1:0] ei;
    logic       es;
    rst_n = r; en = e; req = q;
    @(posedge clk);
    model_step();
    @(negedge clk);
    n_cyc++;
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    ei = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    es = (m_owner >= 0);
    n_cmp++;
    if (grant !== eg || grant_id !== ei || gs !== es || idle !== m_idle) begin
      n_bad++;
      $display("FAIL model cyc%0d: got g=%b id=%0d gs=%b idle=%b want g=%b id=%0d gs=%b idle=%b",
               n_cyc, grant, grant_id, gs, idle, eg, ei, es, m_idle);
    end
  endtask

  task automatic chk(input string nm, input logic [3:0] eg,
                     input logic [1:0] ei, input logic es, input logic eid);
    n_cmp++;
    if (grant !== eg || grant_id !== ei || gs !== es || idle !== eid) begin
      n_bad++;
      $display("FAIL %s: got g=%b id=%0d gs=%b idle=%b want g=%b id=%0d gs=%b idle=%b",
               nm, grant, grant_id, gs, idle, eg, ei, es, eid);
    end
  endtask

  logic [4:0] vec [16] = '{
    5'b1_0110, 5'b1_0110, 5'b1_0010, 5'b1_1100, 5'b1_1000, 5'b1_0001,
    5'b0_1111, 5'b1_0000, 5'b1_0000, 5'b1_1111, 5'b1_1011, 5'b1_0011,
    5'b1_0100, 5'b1_1110, 5'b0_0000, 5'b1_1001
  };

  initial begin
    // reset
    cyc(1'b0, 1'b0, 4'b0000);
    cyc(1'b0, 1'b0, 4'b0000);
    chk("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

    // all requesting after reset: requester 0 first
    cyc(1'b1, 1'b1, 4'b1111);
    chk("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
`ifndef ARB_TIMEOUT_EN
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 4'b1111);
    chk("hold_forever", 4'b0001, 2'd0, 1'b1, 1'b0);
`endif

    // handoff without bubble, then release to idle
    cyc(1'b0, 1'b1, 4'b0000);
    cyc(1'b1, 1'b1, 4'b0101);
    chk("own0", 4'b0001, 2'd0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 4'b0100);
    chk("handoff2", 4'b0100, 2'd2, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 4'b0000);
    chk("release", 4'b0000, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 4'b0000);
    chk("idle_late", 4'b0000, 2'd0, 1'b0, 1'b1);

    // wrap-around
    cyc(1'b0, 1'b1, 4'b0000);
    cyc(1'b1, 1'b1, 4'b1001);
    chk("wrap0", 4'b0001, 2'd0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 4'b1000);
    chk("wrap3", 4'b1000, 2'd3, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 4'b0001);
    chk("wrapback0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // enable drop keeps pointer
    cyc(1'b0, 1'b1, 4'b0000);
    cyc(1'b1, 1'b1, 4'b0010);
    chk("own1", 4'b0010, 2'd1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 4'b0010);
    chk("en_off", 4'b0000, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 4'b1111);
    chk("ptr_kept", 4'b0100, 2'd2, 1'b1, 1'b0);

    // reset mid-grant
    cyc(1'b0, 1'b1, 4'b1111);
    chk("rst_mid", 4'b0000, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 4'b1010);
    chk("after_rst", 4'b0010, 2'd1, 1'b1, 1'b0);

`ifdef ARB_TIMEOUT_EN
    cyc(1'b0, 1'b1, 4'b0000);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b1, 4'b0011);
      if (((i / MH) % 2) == 0) chk("to_alt0", 4'b0001, 2'd0, 1'b1, 1'b0);
      else chk("to_alt1", 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, 4'b0001);
      chk("to_solo", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
`endif

    // mixed directed vectors, model-checked
    cyc(1'b0, 1'b1, 4'b0000);
    for (int i = 0; i < 16; i++) cyc(1'b1, vec[i][4], vec[i][3:0]);
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 4'b1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
